rgb_pixel_fetch: RTL

- Downstream consumer of the colourspace/upsampling stage.
- Once that stage asserts done, this block reads the interleaved RGB frame it wrote to SRAM (two pixels per three 16-bit words).
- It re-assembles 24-bit pixels and streams them through a valid/ready pixel FIFO to the display/readout logic.
- It is read-only on SRAM and owns the SRAM port only while busy.

---
 rtl/rgb_pixel_fetch.sv | 307 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/rgb_pixel_fetch.sv
// Generic single-clock FIFO with an occupancy count and a first-word-fall-through head.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: a push into a full FIFO is dropped; callers must reserve space first.
module rgb_fetch_fifo #(
    parameter int WIDTH = 27,
    parameter int DEPTH = 8
) (
    input  logic                       Clock,
    input  logic                       Resetn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_dat,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             wr_en;
    logic             rd_en;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign wr_en    = push && !full;
    assign rd_en    = pop && !empty;
    assign head_dat = mem[rd_ptr];

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage array; contents are only meaningful below the occupancy count.
    always_ff @(posedge Clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Read/write pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_en) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// Reads the interleaved RGB frame from SRAM and streams 24-bit pixels with sol/eol/eof flags.
// Latency: first pixel reaches the head four cycles after the first read address is driven.
// Backpressure: reads stall in RESERVE until FIFO count plus outstanding pixels leaves room for a pair.
module rgb_pixel_fetch #(
    parameter logic [17:0] RGB_BASE    = 18'd146944,
    parameter int          PIX_PER_ROW = 320,
    parameter int          ROWS        = 240,
    parameter int          FIFO_DEPTH  = 8
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        start,
    input  logic [15:0] SRAM_read_data,
    output logic [17:0] SRAM_address,
    output logic        SRAM_we_n,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [23:0] pix_data,
    output logic        pix_sol,
    output logic        pix_eol,
    output logic        pix_eof,
    output logic        busy,
    output logic        done
);
    localparam int GROUPS = PIX_PER_ROW * ROWS / 2;
    localparam int GW     = $clog2(GROUPS + 1);
    localparam int CW     = $clog2(FIFO_DEPTH + 1);
    localparam int COLW   = (PIX_PER_ROW > 1) ? $clog2(PIX_PER_ROW) : 1;
    localparam int ROWW   = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESERVE,
        S_RD0,
        S_RD1,
        S_RD2,
        S_DRAIN
    } state_t;

    // Read tag travelling alongside each SRAM access until its data returns.
    typedef struct packed {
        logic       vld;
        logic [1:0] sel;
    } tag_t;

    // One FIFO entry: pixel colour plus its frame-position flags.
    typedef struct packed {
        logic        sol;
        logic        eol;
        logic        eof;
        logic [23:0] rgb;
    } pix_ent_t;

    state_t          state;
    logic [17:0]     word_addr;
    logic [GW-1:0]   grp;
    logic [CW-1:0]   pending;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic            space_ok;
    logic            last_group;
    logic            reserve;
    logic            issue;
    logic            drain_done;
    logic            start_acc;

    tag_t            tag_in;
    tag_t            tag1;
    tag_t            tag2;
    logic [7:0]      r_even;
    logic [7:0]      g_even;
    logic [7:0]      r_odd;
    logic [COLW-1:0] col;
    logic [ROWW-1:0] row;

    logic            push;
    logic            pop;
    pix_ent_t        push_ent;
    pix_ent_t        head_ent;

    // Never writes SRAM.
    assign SRAM_we_n = 1'b1;

    // Outstanding pixels plus queued pixels must leave room for one more pair.
    assign space_ok   = ({1'b0, fifo_count} + {1'b0, pending}) <= (CW+1)'(FIFO_DEPTH - 2);
    assign last_group = (grp == GW'(GROUPS - 1));
    assign reserve    = space_ok && ((state == S_RESERVE) || ((state == S_RD2) && !last_group));
    assign issue      = reserve || (state == S_RD0) || (state == S_RD1);
    assign start_acc  = (state == S_IDLE) && start;
    // Finishing on the pop of the final pixel lets done follow that pop by one cycle.
    assign drain_done = (pending == '0) &&
                        ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop));

    // Frame sequencer: space reservation, read address generation, busy/done handshake.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state        <= S_IDLE;
            SRAM_address <= '0;
            word_addr    <= '0;
            grp          <= '0;
            pending      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done    <= 1'b0;
            pending <= pending + (reserve ? CW'(2) : CW'(0)) - (push ? CW'(1) : CW'(0));
            if (issue) begin
                SRAM_address <= word_addr;
                word_addr    <= word_addr + 18'd1;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_RESERVE;
                        busy      <= 1'b1;
                        word_addr <= RGB_BASE;
                        grp       <= '0;
                    end
                end
                S_RESERVE: begin
                    if (space_ok) begin
                        state <= S_RD0;
                    end
                end
                S_RD0: state <= S_RD1;
                S_RD1: state <= S_RD2;
                S_RD2: begin
                    grp <= grp + 1'b1;
                    if (last_group) begin
                        state <= S_DRAIN;
                    end else if (space_ok) begin
                        state <= S_RD0;
                    end else begin
                        state <= S_RESERVE;
                    end
                end
                S_DRAIN: begin
                    if (drain_done) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // The address register is live exactly while in a read state, so tag from the state.
    always_comb begin
        tag_in     = '0;
        tag_in.vld = (state == S_RD0) || (state == S_RD1) || (state == S_RD2);
        case (state)
            S_RD1:   tag_in.sel = 2'd1;
            S_RD2:   tag_in.sel = 2'd2;
            default: tag_in.sel = 2'd0;
        endcase
    end

    // Two-stage tag delay matching the SRAM read latency.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            tag1 <= '0;
            tag2 <= '0;
        end else begin
            tag1 <= tag_in;
            tag2 <= tag1;
        end
    end

    // Words 1 and 2 of each group complete a pixel; word 0 only contributes bytes.
    assign push = tag2.vld && (tag2.sel != 2'd0);

    // Assemble the pixel being pushed and its position flags.
    always_comb begin
        push_ent     = '0;
        push_ent.sol = (col == '0);
        push_ent.eol = (col == COLW'(PIX_PER_ROW - 1));
        push_ent.eof = push_ent.eol && (row == ROWW'(ROWS - 1));
        if (tag2.sel == 2'd1) begin
            push_ent.rgb = {r_even, g_even, SRAM_read_data[15:8]};
        end else begin
            push_ent.rgb = {r_odd, SRAM_read_data[15:8], SRAM_read_data[7:0]};
        end
    end

    // Hold the bytes of a pixel that straddles two words.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_even <= '0;
            g_even <= '0;
            r_odd  <= '0;
        end else if (tag2.vld) begin
            if (tag2.sel == 2'd0) begin
                r_even <= SRAM_read_data[15:8];
                g_even <= SRAM_read_data[7:0];
            end else if (tag2.sel == 2'd1) begin
                r_odd  <= SRAM_read_data[7:0];
            end
        end
    end

    // Column/row position of the next pixel to be pushed.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            col <= '0;
            row <= '0;
        end else if (start_acc) begin
            col <= '0;
            row <= '0;
        end else if (push) begin
            if (col == COLW'(PIX_PER_ROW - 1)) begin
                col <= '0;
                row <= (row == ROWW'(ROWS - 1)) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    rgb_fetch_fifo #(
        .WIDTH ($bits(pix_ent_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .push     (push),
        .push_dat (push_ent),
        .pop      (pop),
        .head_dat (head_ent),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign pix_valid = !fifo_empty;
    assign pop       = pix_valid && pix_ready;
    assign pix_data  = pix_valid ? head_ent.rgb : 24'd0;
    assign pix_sol   = pix_valid && head_ent.sol;
    assign pix_eol   = pix_valid && head_ent.eol;
    assign pix_eof   = pix_valid && head_ent.eof;
endmodule
